// File: rtl/ctrl_decode_seq.sv
// ctrl_decode_seq: registered RV32I control decoder between fetch and execute.
// Instruction in over valid/ready, one registered control bundle out over
// valid/ready; stalls further decode while an issued load/store awaits mem_ack.
// Ports: clk, nrst (sync active-low), flush, inst_valid/inst_ready/instruction,
//   ctrl_valid/ctrl_ready, mem_ack, alu_op, branch_type, control flags,
//   illegal, mem_timeout.
// Optional: define CTRL_MEM_TIMEOUT_EN to abandon MEM_WAIT after MEM_TIMEOUT
//   cycles without mem_ack and raise sticky mem_timeout.

module ctrl_decode_seq #(
    parameter int XLEN        = 32,
    parameter int ALU_OP_W    = 4,
    parameter int BR_W        = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                flush,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [XLEN-1:0]     instruction,
    output logic                ctrl_valid,
    input  logic                ctrl_ready,
    input  logic                mem_ack,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [BR_W-1:0]     branch_type,
    output logic                reg_write_en,
    output logic                alu_mux_en,
    output logic                mem_to_reg,
    output logic                read_mem,
    output logic                write_mem,
    output logic                store_byte,
    output logic                load_byte,
    output logic                pc_absolute_jump_vec,
    output logic                read_next_pc,
    output logic                illegal,
    output logic                mem_timeout
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("ctrl_decode_seq: XLEN must be 32");
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_tmo
        $error("ctrl_decode_seq: MEM_TIMEOUT must be >= 1");
    end

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_IMM  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(10);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [BR_W-1:0]     branch_type;
        logic                reg_write_en;
        logic                alu_mux_en;
        logic                mem_to_reg;
        logic                read_mem;
        logic                write_mem;
        logic                store_byte;
        logic                load_byte;
        logic                pc_absolute_jump_vec;
        logic                read_next_pc;
        logic                illegal;
    } ctrl_t;

    typedef enum logic [1:0] {IDLE, HOLD, MEM_WAIT} state_t;

    state_t state, state_nx;
    ctrl_t  bundle, dec;
    logic   dec_ok, accept, to_hit;

    wire [6:0] opcode = instruction[6:0];
    wire [2:0] f3     = instruction[14:12];
    wire [6:0] f7     = instruction[31:25];
    wire       f7_zero = (f7 == 7'b0000000);
    wire       f7_alt  = (f7 == 7'b0100000);

    logic unused_bits;
    assign unused_bits = ^{instruction[24:15], instruction[11:7]};

    // Shared funct3 -> ALU mapping for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [ALU_OP_W-1:0] alu_of(input logic [2:0] f,
                                                   input logic alt);
        case (f)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        unique case (1'b1)
            opcode == OP_REG: begin
                dec.reg_write_en = 1'b1;
                dec.alu_op       = alu_of(f3, f7_alt);
                dec_ok = f7_zero |
                         (f7_alt & ((f3 == 3'b000) | (f3 == 3'b101)));
            end
            opcode == OP_IMM: begin
                // Only shifts constrain funct7; it is immediate data otherwise.
                dec.reg_write_en = 1'b1;
                dec.alu_mux_en   = 1'b1;
                dec.alu_op       = alu_of(f3, (f3 == 3'b101) & f7_alt);
                if (f3 == 3'b001)
                    dec_ok = f7_zero;
                else if (f3 == 3'b101)
                    dec_ok = f7_zero | f7_alt;
            end
            opcode == OP_LOAD: begin
                dec.reg_write_en = 1'b1;
                dec.alu_mux_en   = 1'b1;
                dec.mem_to_reg   = 1'b1;
                dec.read_mem     = 1'b1;
                dec.load_byte    = (f3 == 3'b000);
                dec_ok = (f3 == 3'b000) | (f3 == 3'b010);
            end
            opcode == OP_STORE: begin
                dec.alu_mux_en = 1'b1;
                dec.write_mem  = 1'b1;
                dec.store_byte = (f3 == 3'b000);
                dec_ok = (f3 == 3'b000) | (f3 == 3'b010);
            end
            opcode == OP_LUI: begin
                dec.reg_write_en = 1'b1;
                dec.alu_mux_en   = 1'b1;
                dec.alu_op       = ALU_IMM;
            end
            opcode == OP_BRANCH: begin
                dec.alu_op = ALU_SUB;
                case (f3)
                    3'b000:  dec.branch_type = BR_W'(1);
                    3'b001:  dec.branch_type = BR_W'(2);
                    3'b100:  dec.branch_type = BR_W'(3);
                    3'b101:  dec.branch_type = BR_W'(4);
                    3'b110:  dec.branch_type = BR_W'(5);
                    3'b111:  dec.branch_type = BR_W'(6);
                    default: dec_ok = 1'b0;
                endcase
            end
            opcode == OP_JAL: begin
                dec.branch_type  = BR_W'(7);
                dec.reg_write_en = 1'b1;
                dec.read_next_pc = 1'b1;
            end
            opcode == OP_JALR: begin
                dec.branch_type          = BR_W'(7);
                dec.reg_write_en         = 1'b1;
                dec.read_next_pc         = 1'b1;
                dec.pc_absolute_jump_vec = 1'b1;
                dec_ok = (f3 == 3'b000);
            end
            default: dec_ok = 1'b0;
        endcase
        if (!dec_ok) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    wire bundle_mem = bundle.read_mem | bundle.write_mem;

    always_comb begin
        inst_ready = 1'b0;
        state_nx   = state;
        if (nrst && !flush) begin
            case (state)
                IDLE:     inst_ready = 1'b1;
                HOLD:     inst_ready = ctrl_ready & ~bundle_mem;
                MEM_WAIT: inst_ready = mem_ack;
                default:  inst_ready = 1'b0;
            endcase
        end
        accept = inst_valid & inst_ready;
        case (state)
            IDLE:
                if (accept) state_nx = HOLD;
            HOLD:
                if (ctrl_ready) begin
                    if (bundle_mem)  state_nx = MEM_WAIT;
                    else if (accept) state_nx = HOLD;
                    else             state_nx = IDLE;
                end
            MEM_WAIT:
                if (mem_ack)     state_nx = accept ? HOLD : IDLE;
                else if (to_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= IDLE;
            bundle <= '0;
        end else begin
            state <= state_nx;
            // Idle carries no bundle, so a flush discards it too.
            if (state_nx == IDLE) bundle <= '0;
            else if (accept)      bundle <= dec;
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             to_flag;

    assign to_hit = (state == MEM_WAIT) && !mem_ack &&
                    (to_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Held at zero outside MEM_WAIT, so every entry starts from zero.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state != MEM_WAIT) to_cnt <= '0;
            else if (!mem_ack)     to_cnt <= to_cnt + CNT_W'(1);
            if (to_hit && !flush)  to_flag <= 1'b1;
        end
    end

    assign mem_timeout = to_flag;
`else
    assign to_hit      = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    assign ctrl_valid           = (state == HOLD);
    assign alu_op               = bundle.alu_op;
    assign branch_type          = bundle.branch_type;
    assign reg_write_en         = bundle.reg_write_en;
    assign alu_mux_en           = bundle.alu_mux_en;
    assign mem_to_reg           = bundle.mem_to_reg;
    assign read_mem             = bundle.read_mem;
    assign write_mem            = bundle.write_mem;
    assign store_byte           = bundle.store_byte;
    assign load_byte            = bundle.load_byte;
    assign pc_absolute_jump_vec = bundle.pc_absolute_jump_vec;
    assign read_next_pc         = bundle.read_next_pc;
    assign illegal              = bundle.illegal;

endmodule

// File: doc/ctrl_decode_seq.md
Name: ctrl_decode_seq

Overview:
Registered, parametrised RV32I control decoder that replaces the purely combinational control path. It sits between fetch and execute.
- Accepts a full 32-bit instruction over a valid/ready handshake.
- Decodes opcode/funct3/funct7 into one registered control bundle, presented downstream with valid/ready.
- Holds off further decode while an issued load/store awaits memory acknowledge.
- Flags illegal encodings; supports flush.

Parameters:
XLEN, 32, instruction width; only 32 is legal, elaboration error otherwise.
ALU_OP_W, 4, width of alu_op.
BR_W, 3, width of branch_type.
MEM_TIMEOUT, 15, cycles allowed in MEM_WAIT before timeout (optional feature only), must be >= 1.

Ports:
clk  in  1  clock, all state on rising edge.
nrst  in  1  synchronous active-low reset.
flush  in  1  discard held bundle and any pending memory wait.
inst_valid  in  1  instruction offered.
inst_ready  out  1  instruction accepted this cycle when high with inst_valid.
instruction  in  XLEN  raw instruction word.
ctrl_valid  out  1  control bundle valid.
ctrl_ready  in  1  execute consumes bundle.
mem_ack  in  1  memory completed the issued load/store.
alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 IMM, 9 SLT, 10 SLTU.
branch_type  out  BR_W  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 jump.
reg_write_en, alu_mux_en, mem_to_reg, read_mem, write_mem, store_byte, load_byte, pc_absolute_jump_vec, read_next_pc  out  1 each  control flags.
illegal  out  1  bundle is an unrecognised encoding; all other flags 0.
mem_timeout  out  1  sticky timeout flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset (nrst=0 at edge): state IDLE; every output 0, including ctrl_valid, all flags, alu_op and branch_type. inst_ready=0 during reset.
- States: IDLE (no bundle), HOLD (bundle registered, ctrl_valid=1), MEM_WAIT (memory op consumed, awaiting mem_ack).
- inst_ready is combinational:
  - IDLE: 1.
  - HOLD: ctrl_ready & ~(read_mem|write_mem).
  - MEM_WAIT: mem_ack.
  - Always 0 when flush=1.
- Accept (inst_valid&inst_ready): decoded bundle registered. Latency 1 cycle; next state HOLD.
- HOLD with ctrl_ready:
  - Non-memory op, no accept: go IDLE, ctrl_valid=0.
  - Non-memory op with accept: stay HOLD with new bundle (back-to-back throughput 1/cycle).
  - Memory op: go MEM_WAIT, ctrl_valid=0.
- HOLD without ctrl_ready: bundle and all outputs stable.
- MEM_WAIT: mem_ack with accept -> HOLD with new bundle; mem_ack alone -> IDLE. mem_ack outside MEM_WAIT is ignored.
- flush: next state IDLE, ctrl_valid=0, no accept that cycle; overrides every other event. nrst overrides flush.
- Decode rules:
  - R-type (0110011): per funct7/funct3; slt->SLT, sltu->SLTU; reg_write_en=1.
  - OP-IMM (0010011): same mapping from funct3; srai needs funct7=0100000; alu_mux_en=1.
  - Loads: lb and lw only; read_mem=1, mem_to_reg=1, alu_mux_en=1, ADD; lb sets load_byte.
  - Stores: sb and sw only; write_mem=1, alu_mux_en=1, ADD, reg_write_en=0; sb sets store_byte.
  - lui: alu_op=IMM, alu_mux_en=1.
  - Branches: SUB, reg_write_en=0, branch_type per funct3.
  - jal/jalr: branch_type=7, reg_write_en=1, read_next_pc=1, pc_absolute_jump_vec=1 for jalr only.
  - Anything else: illegal=1, passes the handshake as a normal non-memory bundle.

Optional Feature:
CTRL_MEM_TIMEOUT_EN.
- Defined: counter cleared on MEM_WAIT entry, increments each MEM_WAIT cycle without mem_ack. On reaching MEM_TIMEOUT: set mem_timeout (sticky until nrst), go IDLE.
- Undefined: no counter, MEM_WAIT waits indefinitely, mem_timeout tied 0.

Test Plan:
- Reset, then 0x002081B3 (add), ctrl_ready=1 -> ctrl_valid next cycle, alu_op=0, reg_write_en=1, alu_mux_en=0; 0x402081B3 back-to-back -> alu_op=1 the following cycle, no bubble.
- 0x0000A183 (lw), ctrl_ready=1 -> read_mem=1, mem_to_reg=1, load_byte=0; inst_ready=0 until mem_ack pulses 3 cycles later; next instruction accepted in the mem_ack cycle.
- 0x00208063 (beq) with ctrl_ready=0 for 4 cycles -> bundle stable, branch_type=1, reg_write_en=0, inst_ready=0; consumed on cycle 5.
- 0xFFFFFFFF -> illegal=1, all other flags 0, alu_op=0, normal handshake.
- lw issued, flush asserted in MEM_WAIT -> IDLE next cycle, later mem_ack ignored; nrst low mid-HOLD -> all outputs 0 next edge.
- CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=15: sw 0x0020A023 with no mem_ack -> mem_timeout=1 after 15 MEM_WAIT cycles, state IDLE, inst_ready=1.
